// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: game state encoding, fruit boxes and fruit bit indices.
package pacman_pkg;

  typedef enum logic [1:0] {
    StPlay,
    StDying,
    StGameOver,
    StWin
  } game_state_t;

  // Fruit bit positions in the fruits vector
  localparam int unsigned FruitApple  = 0;
  localparam int unsigned FruitPeas   = 1;
  localparam int unsigned FruitGrapes = 2;
  localparam int unsigned FruitDrink  = 3;
  localparam int unsigned NumFruits   = 4;

  // Fruit boxes, inclusive bounds in screen pixels
  localparam logic [9:0] AppleXMin  = 10'd12;
  localparam logic [9:0] AppleXMax  = 10'd38;
  localparam logic [9:0] AppleYMin  = 10'd10;
  localparam logic [9:0] AppleYMax  = 10'd35;
  localparam logic [9:0] PeasXMin   = 10'd372;
  localparam logic [9:0] PeasXMax   = 10'd396;
  localparam logic [9:0] PeasYMin   = 10'd10;
  localparam logic [9:0] PeasYMax   = 10'd34;
  localparam logic [9:0] GrapesXMin = 10'd12;
  localparam logic [9:0] GrapesXMax = 10'd38;
  localparam logic [9:0] GrapesYMin = 10'd414;
  localparam logic [9:0] GrapesYMax = 10'd439;
  localparam logic [9:0] DrinkXMin  = 10'd370;
  localparam logic [9:0] DrinkXMax  = 10'd396;
  localparam logic [9:0] DrinkYMin  = 10'd413;
  localparam logic [9:0] DrinkYMax  = 10'd439;

  function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                  input logic [9:0] x_min, input logic [9:0] x_max,
                                  input logic [9:0] y_min, input logic [9:0] y_max);
    return (x >= x_min) && (x <= x_max) && (y >= y_min) && (y <= y_max);
  endfunction

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit vector.
module popcount32 (
  input  logic [31:0] bits,
  output logic [5:0]  count
);

  // Sum of all set bits
  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + 6'(bits[i]);
    end
  end

endmodule

// File: rtl/game_status.sv
// Game bookkeeping: score, lives, fruits and the play/dying/game-over/win state machine.
module game_status
  import pacman_pkg::*;
#(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned DEATH_FRAMES = 120,
  parameter int unsigned DOT_POINTS   = 1,
  parameter int unsigned FRUIT_POINTS = 10,
  parameter int unsigned SCORE_MAX    = 999
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  Ball_size,
  input  logic [9:0]  redghostX,
  input  logic [9:0]  redghostY,
  input  logic [9:0]  redghost_size,
  input  logic [31:0] dots_left,
  output logic [9:0]  score,
  output logic [7:0]  lives,
  output logic [3:0]  fruits,
  output logic        freeze,
  output logic        respawn,
  output logic        game_over,
  output logic        win
);

  localparam int unsigned CntW = $clog2(DEATH_FRAMES + 1);

  game_state_t     state_q, state_d;
  logic [9:0]      score_q, score_d;
  logic [7:0]      lives_q, lives_d;
  logic [3:0]      fruits_q, fruits_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     dots_prev_q;
  logic            respawn_q, respawn_d;
  logic            freeze_q, game_over_q, win_q;

  logic [31:0]        new_dots;
  logic [5:0]         new_cnt;
  logic [NumFruits-1:0] fruit_in, fruit_hit;
  logic signed [10:0] dx, dy;
  logic signed [21:0] dx_w, dy_w;
  logic [21:0]        dx2, dy2, rsq;
  logic [10:0]        rsum;
  logic [22:0]        dist2;
  logic               ghost_hit;
  logic               play_tick;
  logic [15:0]        add;
  logic [16:0]        sum;

  assign new_dots = dots_left & ~dots_prev_q;

  popcount32 u_popcount32 (
    .bits  (new_dots),
    .count (new_cnt)
  );

  assign play_tick = frame_tick && (state_q == StPlay);

  assign fruit_in[FruitApple]  = in_box(BallX, BallY, AppleXMin, AppleXMax, AppleYMin, AppleYMax);
  assign fruit_in[FruitPeas]   = in_box(BallX, BallY, PeasXMin, PeasXMax, PeasYMin, PeasYMax);
  assign fruit_in[FruitGrapes] = in_box(BallX, BallY, GrapesXMin, GrapesXMax, GrapesYMin,
                                        GrapesYMax);
  assign fruit_in[FruitDrink]  = in_box(BallX, BallY, DrinkXMin, DrinkXMax, DrinkYMin, DrinkYMax);
  assign fruit_hit = play_tick ? (fruit_in & ~fruits_q) : '0;

  // Circle overlap: squared centre distance against squared radius sum, no overflow
  assign dx    = $signed({1'b0, BallX}) - $signed({1'b0, redghostX});
  assign dy    = $signed({1'b0, BallY}) - $signed({1'b0, redghostY});
  assign dx_w  = 22'(dx);
  assign dy_w  = 22'(dy);
  assign dx2   = unsigned'(dx_w * dx_w);
  assign dy2   = unsigned'(dy_w * dy_w);
  assign dist2 = {1'b0, dx2} + {1'b0, dy2};
  assign rsum  = {1'b0, Ball_size} + {1'b0, redghost_size};
  assign rsq   = 22'(rsum) * 22'(rsum);
  assign ghost_hit = dist2 < {1'b0, rsq};

  // Dot and fruit points summed before a single saturation
  always_comb begin
    add = 16'(new_cnt) * 16'(DOT_POINTS);
    for (int i = 0; i < NumFruits; i++) begin
      if (fruit_hit[i]) add = add + 16'(FRUIT_POINTS);
    end
    sum = 17'(score_q) + 17'(add);
  end

  // Next-state logic for the game FSM and its bookkeeping
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    fruits_d  = fruits_q;
    cnt_d     = cnt_q;
    respawn_d = 1'b0;
    unique case (state_q)
      StPlay: begin
        score_d  = (sum > 17'(SCORE_MAX)) ? 10'(SCORE_MAX) : sum[9:0];
        fruits_d = fruits_q | fruit_hit;
        if (frame_tick) begin
          if (&dots_left) begin
            state_d = StWin;
          end else if (ghost_hit) begin
            state_d = StDying;
            lives_d = (lives_q == 8'd0) ? 8'd0 : lives_q - 8'd1;
            cnt_d   = CntW'(DEATH_FRAMES);
          end
        end
      end
      StDying: begin
        if (frame_tick) begin
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
          // Last tick of the dying animation
          if (cnt_q <= CntW'(1)) begin
            if (lives_q == 8'd0) begin
              state_d = StGameOver;
            end else begin
              state_d   = StPlay;
              respawn_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StPlay;
      score_q     <= '0;
      lives_q     <= 8'(START_LIVES);
      fruits_q    <= '0;
      cnt_q       <= '0;
      dots_prev_q <= '0;
      respawn_q   <= 1'b0;
      freeze_q    <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      fruits_q    <= fruits_d;
      cnt_q       <= cnt_d;
      dots_prev_q <= dots_left;
      respawn_q   <= respawn_d;
      freeze_q    <= (state_d != StPlay);
      game_over_q <= (state_d == StGameOver);
      win_q       <= (state_d == StWin);
    end
  end

  assign score     = score_q;
  assign lives     = lives_q;
  assign fruits    = fruits_q;
  assign freeze    = freeze_q;
  assign respawn   = respawn_q;
  assign game_over = game_over_q;
  assign win       = win_q;

endmodule

// File: tb/tb_game_status.sv
// Self-checking bench for game_status against a behavioural game model.
module tb_game_status;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick;
  logic [9:0]  BallX, BallY, Ball_size;
  logic [9:0]  redghostX, redghostY, redghost_size;
  logic [31:0] dots_left;
  logic [9:0]  score;
  logic [7:0]  lives;
  logic [3:0]  fruits;
  logic        freeze, respawn, game_over, win;

  game_status dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .BallX         (BallX),
    .BallY         (BallY),
    .Ball_size     (Ball_size),
    .redghostX     (redghostX),
    .redghostY     (redghostY),
    .redghost_size (redghost_size),
    .dots_left     (dots_left),
    .score         (score),
    .lives         (lives),
    .fruits        (fruits),
    .freeze        (freeze),
    .respawn       (respawn),
    .game_over     (game_over),
    .win           (win)
  );

  always #5 Clk = ~Clk;

  // Model: mode 0 playing, 1 dying, 2 game over, 3 won
  int          m_score, m_lives, m_mode, m_remain;
  logic [3:0]  m_fruits;
  logic [31:0] m_prev;
  logic        m_resp;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("score", 32'(score), 32'(m_score));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("fruits", 32'(fruits), 32'(m_fruits));
    chk("freeze", 32'(freeze), 32'(m_mode != 0));
    chk("respawn", 32'(respawn), 32'(m_resp));
    chk("game_over", 32'(game_over), 32'(m_mode == 2));
    chk("win", 32'(win), 32'(m_mode == 3));
  endtask

  task automatic model_reset();
    m_score = 0; m_lives = 3; m_mode = 0; m_remain = 0;
    m_fruits = '0; m_prev = '0; m_resp = 1'b0;
  endtask

  function automatic bit on_fruit(input int idx, input int x, input int y);
    case (idx)
      0: return x >= 12 && x <= 38 && y >= 10 && y <= 35;
      1: return x >= 372 && x <= 396 && y >= 10 && y <= 34;
      2: return x >= 12 && x <= 38 && y >= 414 && y <= 439;
      default: return x >= 370 && x <= 396 && y >= 413 && y <= 439;
    endcase
  endfunction

  // One clock of the game rules, evaluated with the inputs present before the edge
  task automatic model_step();
    int add, ddx, ddy, rr;
    logic [31:0] fresh;
    fresh  = dots_left & ~m_prev;
    m_prev = dots_left;
    m_resp = 1'b0;
    if (m_mode == 0) begin
      add = $countones(fresh);
      if (frame_tick) begin
        for (int i = 0; i < 4; i++) begin
          if (on_fruit(i, int'(BallX), int'(BallY)) && !m_fruits[i]) begin
            m_fruits[i] = 1'b1;
            add += 10;
          end
        end
        ddx = int'(BallX) - int'(redghostX);
        ddy = int'(BallY) - int'(redghostY);
        rr  = int'(Ball_size) + int'(redghost_size);
        if (dots_left == 32'hFFFF_FFFF) m_mode = 3;
        else if (ddx * ddx + ddy * ddy < rr * rr) begin
          m_mode = 1;
          m_remain = 120;
          if (m_lives > 0) m_lives--;
        end
      end
      m_score = (m_score + add > 999) ? 999 : m_score + add;
    end else if (m_mode == 1 && frame_tick) begin
      m_remain--;
      if (m_remain == 0) begin
        if (m_lives == 0) m_mode = 2;
        else begin
          m_mode = 0;
          m_resp = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit tk);
    frame_tick = tk;
    model_step();
    @(posedge Clk);
    #1;
    check_all();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    @(negedge Clk);
    check_all();
    Reset_n = 1'b1;
  endtask

  task automatic place(input int bx, input int by, input int gx, input int gy);
    BallX = 10'(bx); BallY = 10'(by); redghostX = 10'(gx); redghostY = 10'(gy);
  endtask

  initial begin
    int k;
    frame_tick = 1'b0; dots_left = '0;
    Ball_size = 10'd12; redghost_size = 10'd12;
    place(100, 100, 300, 300);
    do_reset();

    // Dots: four new dots give four points, holding adds nothing
    dots_left = 32'h0000_000F;
    step(0);
    chk("dots4", 32'(score), 32'd4);
    step(0);
    chk("dots_hold", 32'(score), 32'd4);

    // Apple once only
    place(20, 20, 300, 300);
    step(1);
    chk("apple_bit", 32'(fruits), 32'd1);
    chk("apple_pts", 32'(score), 32'd14);
    step(1);
    chk("apple_again", 32'(score), 32'd14);

    // Climb to 995 with batches of dots, then saturate
    place(100, 100, 300, 300);
    while (m_score < 995) begin
      k = (995 - m_score > 31) ? 31 : 995 - m_score;
      dots_left = '0;
      step(0);
      dots_left = (32'h1 << k) - 32'h1;
      step(0);
    end
    chk("at995", 32'(score), 32'd995);
    dots_left = '0;
    step(0);
    dots_left = 32'h0000_00FF;
    step(0);
    chk("sat_dots", 32'(score), 32'd999);
    place(380, 20, 300, 300);
    step(1);
    chk("sat_fruit", 32'(score), 32'd999);
    chk("peas_bit", 32'(fruits), 32'd3);

    // First death, dying animation, respawn
    place(200, 200, 200, 200);
    step(1);
    chk("death_lives", 32'(lives), 32'd2);
    chk("death_freeze", 32'(freeze), 32'd1);
    for (int i = 0; i < 119; i++) step(i % 3 != 2);
    while (m_mode == 1) step(1);
    chk("respawn_pulse", 32'(respawn), 32'd1);
    chk("respawn_unfreeze", 32'(freeze), 32'd0);
    step(0);
    chk("respawn_once", 32'(respawn), 32'd0);

    // Two more deaths lead to game over
    for (int i = 0; i < 250; i++) step(1);
    chk("go_flag", 32'(game_over), 32'd1);
    chk("go_freeze", 32'(freeze), 32'd1);
    chk("go_lives", 32'(lives), 32'd0);
    for (int i = 0; i < 5; i++) step(1);

    // All dots eaten together with a ghost overlap wins
    do_reset();
    dots_left = 32'hFFFF_FFFF;
    step(1);
    chk("win_flag", 32'(win), 32'd1);
    chk("win_lives", 32'(lives), 32'd3);
    for (int i = 0; i < 3; i++) step(1);

    // Reset in the middle of dying
    do_reset();
    dots_left = '0;
    step(0);
    step(1);
    for (int i = 0; i < 10; i++) step(1);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge Clk);
    Reset_n = 1'b1;
    place(100, 100, 300, 300);
    for (int i = 0; i < 4; i++) step(1);
    chk("mid_reset_resp", 32'(respawn), 32'd0);

    // Randomized play
    for (int n = 0; n < 1600; n++) begin
      int bx, by;
      if (n % 400 == 0) begin
        dots_left = '0;
        do_reset();
      end
      bx = $urandom_range(30, 440);
      by = $urandom_range(30, 440);
      if ($urandom_range(0, 3) == 0) begin
        bx = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 40) : $urandom_range(368, 398);
        by = ($urandom_range(0, 1) == 1) ? $urandom_range(8, 37) : $urandom_range(411, 441);
      end
      place(bx, by, bx + $urandom_range(0, 60) - 30, by + $urandom_range(0, 60) - 30);
      Ball_size = 10'($urandom_range(2, 15));
      redghost_size = 10'($urandom_range(2, 15));
      if ($urandom_range(0, 2) == 0) dots_left = dots_left | (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 40) == 0) dots_left = $urandom() & $urandom();
      step($urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_status.md
# game_status

Holds the game's bookkeeping: score, lives, eaten fruits and the play/death/end state. It consumes Pac-Man and red-ghost positions from the movement logic and the `dots_left` vector from `dots`. It drives the `score`, `lives` and `fruits` inputs of `color_mapper`, plus freeze/respawn controls back to the movement logic. It sits directly upstream of `color_mapper`.

## Interface
Parameters:
- `START_LIVES`, 3: lives loaded at reset.
- `DEATH_FRAMES`, 120: frame ticks spent in DYING.
- `DOT_POINTS`, 1: points per newly eaten dot.
- `FRUIT_POINTS`, 10: points per fruit.
- `SCORE_MAX`, 999: saturation value of `score`.

Ports:
- `Clk` in 1: system clock. One clock domain only.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `BallX`, `BallY`, `Ball_size` in 10 each: Pac-Man centre and radius.
- `redghostX`, `redghostY`, `redghost_size` in 10 each: ghost centre and radius.
- `dots_left` in 32: bit = 1 means that dot is eaten.
- `score` out 10: current score.
- `lives` out 8: remaining lives.
- `fruits` out 4: bit = 1 means eaten. Bit order is apple, peas, grapes, drink.
- `freeze` out 1: high means movement logic must hold positions.
- `respawn` out 1: one-cycle pulse; movement logic returns sprites to start positions.
- `game_over` out 1: level indicator of the GAME_OVER state.
- `win` out 1: level indicator of the WIN state.

## Operation
- States are PLAY, DYING, GAME_OVER and WIN.
- Reset values:
  - state = PLAY, `score` = 0, `lives` = START_LIVES, `fruits` = 0.
  - Death counter = 0 and `dots_prev` = 0.
  - `freeze`, `respawn`, `game_over`, `win` all 0.
- Dot scoring runs every cycle in PLAY:
  - new = `dots_left` & ~`dots_prev`; `dots_prev` <= `dots_left`.
  - `score` += popcount(new) × DOT_POINTS, saturating at SCORE_MAX.
  - In all other states `dots_prev` still tracks `dots_left`, but no points are added.
- Fruit hit is evaluated on `frame_tick` in PLAY. Pac-Man's centre must lie inside a fruit box (inclusive bounds) and the fruit bit must be 0:
  - apple: X 12–38, Y 10–35.
  - peas: X 372–396, Y 10–34.
  - grapes: X 12–38, Y 414–439.
  - drink: X 370–396, Y 413–439.
  - On a hit: set the fruit bit and add FRUIT_POINTS (saturating).
- Ghost hit is evaluated on `frame_tick` in PLAY:
  - dx = BallX − redghostX and dy = BallY − redghostY, as signed 11-bit values.
  - Hit when dx² + dy² < (Ball_size + redghost_size)², computed at 22+ bits with no overflow.
- Transitions, on `frame_tick` in PLAY, in priority order:
  1. If `dots_left` = all ones → WIN.
  2. Else on a ghost hit → DYING: `lives` decrements (floor 0) and the counter loads DEATH_FRAMES.
- DYING:
  - Each `frame_tick` decrements the counter.
  - When the counter reaches 0 on a tick: if `lives` = 0 go to GAME_OVER; otherwise pulse `respawn` and go to PLAY.
- GAME_OVER and WIN are terminal until `Reset_n` is asserted.
- `freeze` = 1 in DYING, GAME_OVER and WIN.
- Score additions within one cycle (dots plus fruit) are summed before saturation.

## Timing
- All outputs are registered.
- `score` reflects a `dots_left` change one cycle after it appears.
- Fruit and ghost effects appear the cycle after the `frame_tick` that sampled them.
- `respawn` is high for exactly one cycle: the cycle after the final DYING tick. PLAY resumes in that same cycle.
- `freeze` rises the cycle after the hit tick and falls with the `respawn` cycle.
- `frame_tick` held high for multiple cycles counts once per cycle. The upstream source must guarantee single-cycle pulses.
- `Reset_n` asserted mid-DYING immediately returns all state to the reset values, with no `respawn` pulse.
- Fruit and ghost hits in the same tick: fruit points are credited, then DYING is entered.

## Structure
- Shared package `pacman_pkg` holds:
  - `game_state_t` enum.
  - Fruit box bound constants, also used by `color_mapper`.
  - Fruit bit index constants.
- Sub-module `popcount32`: combinational 32-bit population count producing a 6-bit result.
- Everything else lives in one file:
  - FSM.
  - Death counter: at least $clog2(DEATH_FRAMES+1) bits.
  - Score adder with saturation.
  - Collision comparators.

## Test plan
- Reset then `dots_left` 0 → 0x0000_000F in one cycle → `score` = 4 the next cycle; holding the same value adds nothing.
- Pac-Man at (20,20) with `frame_tick` → `fruits` = 4'b0001 and `score` += 10; a second tick at the same position adds nothing.
- `score` = 995 with 8 new dots → `score` = 999; a further fruit keeps it at 999.
- Ghost and Pac-Man both at (200,200), radius 12, tick →
  - `lives` 3→2 and `freeze` = 1.
  - After 120 ticks, `respawn` is a single-cycle pulse and `freeze` = 0.
- Three deaths → after the third DYING completes, `game_over` = 1, `freeze` = 1, `lives` = 0, and further ticks change nothing.
- `dots_left` all ones with a ghost overlap on the same tick → WIN, `win` = 1 and `lives` unchanged.
- Assert `Reset_n` mid-DYING → reset values, with no `respawn` pulse.
